// File: rtl/fft_out_reorder_if.sv
// Sample stream into and out of the FFT output reorder buffer.
// Input side carries bit-reversed tagged samples; output side carries natural-order bins plus overflow.
interface fft_out_reorder_if #(
    parameter int TOTAL_STAGE_P = 10,
    parameter int MULT_WIDTH_P  = 18
);
    logic                        ien;
    logic [TOTAL_STAGE_P-1:0]    iaddr;
    logic [2*MULT_WIDTH_P-1:0]   idata;
    logic                        oen;
    logic [TOTAL_STAGE_P-1:0]    oaddr;
    logic [2*MULT_WIDTH_P-1:0]   odata;
    logic                        olast;
    logic                        oovf;

    modport master (
        output ien, iaddr, idata,
        input  oen, oaddr, odata, olast, oovf
    );

    modport slave (
        input  ien, iaddr, idata,
        output oen, oaddr, odata, olast, oovf
    );
endinterface

// File: rtl/fft_out_reorder.sv
// Ping-pong reorder buffer: bit-reversed FFT frame in, natural bin order out (FFT_REORDER_IADDR_EN: place by iaddr tag).
// Latency: last write at t -> first bin at t+2, last bin at t+N+1.
// No backpressure: input always accepted, a frame landing on an unread bank sets sticky oovf.
module fft_out_reorder #(
    parameter int TOTAL_STAGE_P = 10,
    parameter int MULT_WIDTH_P  = 18
) (
    input  logic             iclk,
    input  logic             rst,
    fft_out_reorder_if.slave bus
);
    localparam int AW = TOTAL_STAGE_P;
    localparam int DW = 2 * MULT_WIDTH_P;
    localparam int N  = 1 << AW;
    localparam logic [AW-1:0] LAST_IDX = '1;

    typedef enum logic {ST_IDLE, ST_READ} state_t;

    function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] v);
        logic [AW-1:0] r;
        for (int i = 0; i < AW; i++) begin
            r[i] = v[AW-1-i];
        end
        return r;
    endfunction

    logic [AW-1:0] wr_cnt_q, wr_cnt_d;
    logic          wr_bank_q, wr_bank_d;
    logic [1:0]    full_q, full_d;
    logic          ovf_q, ovf_d;
    logic          wr_done;
    logic [AW-1:0] waddr;

    state_t        state_q, state_d;
    logic [AW-1:0] rd_cnt_q, rd_cnt_d;
    logic          rd_bank_q, rd_bank_d;
    logic          rd_issue;
    logic          rd_end;

    logic [DW-1:0] mem_q [2*N];
    logic [DW-1:0] rdata_q;
    logic          oen_q;
    logic [AW-1:0] oaddr_q;
    logic          olast_q;

`ifdef FFT_REORDER_IADDR_EN
    assign waddr = bus.iaddr;
`else
    logic unused_iaddr;
    assign unused_iaddr = ^bus.iaddr;
    assign waddr        = wr_cnt_q;
`endif

    // Write side: completion is by count, so iaddr placement never affects frame boundaries.
    always_comb begin
        wr_done   = bus.ien && (wr_cnt_q == LAST_IDX);
        wr_cnt_d  = bus.ien ? wr_cnt_q + 1'b1 : wr_cnt_q;
        wr_bank_d = wr_done ? ~wr_bank_q : wr_bank_q;
        ovf_d     = ovf_q;
        if (wr_done && full_q[~wr_bank_q] && !(rd_end && (rd_bank_q != wr_bank_q))) begin
            ovf_d = 1'b1;
        end
        full_d = full_q;
        if (rd_end) begin
            full_d[rd_bank_q] = 1'b0;
        end
        if (wr_done) begin
            full_d[wr_bank_q] = 1'b1;
        end
    end

    always_ff @(posedge iclk) begin
        if (rst) begin
            wr_cnt_q  <= '0;
            wr_bank_q <= 1'b0;
            full_q    <= '0;
            ovf_q     <= 1'b0;
        end else begin
            wr_cnt_q  <= wr_cnt_d;
            wr_bank_q <= wr_bank_d;
            full_q    <= full_d;
            ovf_q     <= ovf_d;
        end
    end

    // Read FSM state register
    always_ff @(posedge iclk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            rd_cnt_q  <= '0;
            rd_bank_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_cnt_q  <= rd_cnt_d;
            rd_bank_q <= rd_bank_d;
        end
    end

    // Read FSM next state: start straight off the completion strobe to save a cycle.
    always_comb begin
        state_d   = state_q;
        rd_cnt_d  = rd_cnt_q;
        rd_bank_d = rd_bank_q;
        case (state_q)
            ST_IDLE: begin
                if (wr_done) begin
                    state_d   = ST_READ;
                    rd_bank_d = wr_bank_q;
                    rd_cnt_d  = '0;
                end else if (|full_q) begin
                    state_d   = ST_READ;
                    rd_bank_d = full_q[0] ? 1'b0 : 1'b1;
                    rd_cnt_d  = '0;
                end
            end
            ST_READ: begin
                rd_cnt_d = rd_cnt_q + 1'b1;
                if (rd_end) begin
                    if (full_q[~rd_bank_q] || (wr_done && (wr_bank_q != rd_bank_q))) begin
                        rd_bank_d = ~rd_bank_q;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Read FSM outputs
    always_comb begin
        rd_issue = (state_q == ST_READ);
        rd_end   = rd_issue && (rd_cnt_q == LAST_IDX);
    end

    always_ff @(posedge iclk) begin
        if (bus.ien && !rst) begin
            mem_q[{wr_bank_q, waddr}] <= bus.idata;
        end
    end

    always_ff @(posedge iclk) begin
        if (rst) begin
            rdata_q <= '0;
            oen_q   <= 1'b0;
            oaddr_q <= '0;
            olast_q <= 1'b0;
        end else begin
            oen_q   <= rd_issue;
            olast_q <= rd_end;
            if (rd_issue) begin
                rdata_q <= mem_q[{rd_bank_q, bitrev(rd_cnt_q)}];
                oaddr_q <= rd_cnt_q;
            end
        end
    end

    assign bus.oen   = oen_q;
    assign bus.oaddr = oaddr_q;
    assign bus.odata = rdata_q;
    assign bus.olast = olast_q;
    assign bus.oovf  = ovf_q;
endmodule

// File: tb/tb_fft_out_reorder.sv
// Directed bench for fft_out_reorder at N=16: ordering, back-to-back, gaps, scrambled tags, overflow, reset.
module tb_fft_out_reorder;
    localparam int TS = 4;
    localparam int MW = 18;

    typedef struct packed {
        int unsigned cyc;
        logic [3:0]  a;
        logic [35:0] d;
        logic        l;
    } osmp_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   cyc_n;
    int   t_last;
    int   t0;
    osmp_t obs[$];

    fft_out_reorder_if #(.TOTAL_STAGE_P(TS), .MULT_WIDTH_P(MW)) bus ();

    fft_out_reorder #(.TOTAL_STAGE_P(TS), .MULT_WIDTH_P(MW)) dut (
        .iclk (clk),
        .rst  (rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] br4(input logic [3:0] v);
        return {v[0], v[1], v[2], v[3]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        assert (act === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, act, exp);
        end
    endtask

    // One clock: sample outputs just after the edge, then drive the next cycle's inputs.
    task automatic step(input logic en, input logic [3:0] a, input logic [35:0] d);
        osmp_t s;
        @(posedge clk);
        #1;
        cyc_n++;
        if (bus.oen === 1'b1) begin
            s.cyc = cyc_n;
            s.a   = bus.oaddr;
            s.d   = bus.odata;
            s.l   = bus.olast;
            obs.push_back(s);
        end
        bus.ien   = en;
        bus.iaddr = a;
        bus.idata = d;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 4'd0, 36'd0);
    endtask

    task automatic send_frame(input int base, input bit gap);
        logic [3:0] a;
        for (int j = 0; j < 16; j++) begin
            a = 4'(j);
            step(1'b1, a, 36'(base * 16 + int'(br4(a))));
            t_last = cyc_n;
            if (gap) step(1'b0, 4'd0, 36'd0);
        end
    endtask

    task automatic check_frames(input int ts, input int nfr, input int base, input string tag);
        osmp_t s;
        int idx;
        chk({tag, "_count"}, 64'(obs.size()), 64'(nfr * 16));
        for (int f = 0; f < nfr; f++) begin
            for (int k = 0; k < 16; k++) begin
                idx = f * 16 + k;
                if (idx < obs.size()) s = obs[idx];
                else s = '1;
                chk($sformatf("%s_addr[%0d]", tag, idx), 64'(s.a), 64'(k));
                chk($sformatf("%s_data[%0d]", tag, idx), 64'(s.d), 64'((base + f) * 16 + k));
                chk($sformatf("%s_last[%0d]", tag, idx), 64'(s.l), 64'(k == 15));
                chk($sformatf("%s_cyc[%0d]", tag, idx), 64'(s.cyc), 64'(ts + 2 + idx));
            end
        end
        obs.delete();
    endtask

    logic [3:0] perm [16];
    logic [3:0] pa;

    initial begin
        total = 0;
        bad   = 0;
        cyc_n = 0;
        rst   = 1'b1;
        bus.ien   = 1'b0;
        bus.iaddr = '0;
        bus.idata = '0;
        perm = '{4'd7, 4'd12, 4'd3, 4'd0, 4'd15, 4'd9, 4'd1, 4'd14,
                 4'd4, 4'd10, 4'd6, 4'd13, 4'd2, 4'd11, 4'd8, 4'd5};

        idle(3);
        chk("rst_oen", 64'(bus.oen), 64'd0);
        chk("rst_oaddr", 64'(bus.oaddr), 64'd0);
        chk("rst_odata", 64'(bus.odata), 64'd0);
        chk("rst_olast", 64'(bus.olast), 64'd0);
        chk("rst_oovf", 64'(bus.oovf), 64'd0);
        rst = 1'b0;
        idle(2);
        chk("post_rst_oen", 64'(bus.oen), 64'd0);

        // Bit-reversed frame comes out in natural order.
        send_frame(0, 1'b0);
        t0 = t_last;
        idle(20);
        check_frames(t0, 1, 0, "t1");

        // Three frames with no gaps: 48 contiguous bins.
        send_frame(1, 1'b0);
        t0 = t_last;
        send_frame(2, 1'b0);
        send_frame(3, 1'b0);
        idle(20);
        check_frames(t0, 3, 1, "t2");
        chk("t2_oovf", 64'(bus.oovf), 64'd0);

        // Input valid toggling every cycle.
        send_frame(4, 1'b1);
        t0 = t_last;
        idle(20);
        check_frames(t0, 1, 4, "t3");

        // Scrambled arrival order (in-order when tag placement is compiled out).
        for (int j = 0; j < 16; j++) begin
`ifdef FFT_REORDER_IADDR_EN
            pa = perm[j];
`else
            pa = 4'(j);
`endif
            step(1'b1, pa, 36'(5 * 16 + int'(br4(pa))));
            t_last = cyc_n;
        end
        t0 = t_last;
        idle(20);
        check_frames(t0, 1, 5, "t4");

        // Reset after a partial frame discards it.
        for (int j = 0; j < 7; j++) begin
            step(1'b1, 4'(j), 36'(36'hF00 + j));
        end
        rst = 1'b1;
        step(1'b0, 4'd0, 36'd0);
        chk("t6_rst_oen0", 64'(bus.oen), 64'd0);
        step(1'b0, 4'd0, 36'd0);
        chk("t6_rst_oen1", 64'(bus.oen), 64'd0);
        rst = 1'b0;
        idle(2);
        chk("t6_post_oen", 64'(bus.oen), 64'd0);
        chk("t6_no_output", 64'(obs.size()), 64'd0);
        obs.delete();
        send_frame(6, 1'b0);
        t0 = t_last;
        idle(20);
        check_frames(t0, 1, 6, "t6");

        // Overflow: hold the read counter so the bank being read never frees.
        send_frame(7, 1'b0);
        idle(1);
        force dut.rd_cnt_q = '0;
        chk("t5_oovf_before", 64'(bus.oovf), 64'd0);
        send_frame(8, 1'b0);
        idle(2);
        chk("t5_oovf_set", 64'(bus.oovf), 64'd1);
        send_frame(9, 1'b0);
        idle(1);
        chk("t5_oovf_hold0", 64'(bus.oovf), 64'd1);
        release dut.rd_cnt_q;
        idle(40);
        chk("t5_oovf_hold1", 64'(bus.oovf), 64'd1);
        rst = 1'b1;
        idle(2);
        chk("t5_oovf_clr", 64'(bus.oovf), 64'd0);
        chk("t5_oen_clr", 64'(bus.oen), 64'd0);
        rst = 1'b0;
        idle(2);
        obs.delete();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
